// File: rtl/uart_rx_chunker.sv
// Packs uart_rx bytes into a chunk that is presented when full or after line idle; ready rises on the capturing/timeout edge.
// While a chunk is held the only backpressure is dropping: extra bytes pulse is_overflow and bump a saturating drop_count.
module uart_rx_chunker #(
  parameter int BUFFER_BYTE_SIZE   = 3,
  parameter int BUFFER_INDEX_SIZE  = 32,
  parameter int IDLE_TIMEOUT_TICKS = 100000
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic                          rx_ready,
  input  logic [7:0]                    rx_data,
  input  logic                          chunk_ack,
  output logic                          is_chunk_ready,
  output logic [BUFFER_INDEX_SIZE-1:0]  chunk_byte_size,
  output logic [BUFFER_BYTE_SIZE*8-1:0] chunk_bytes,
  output logic                          is_overflow,
  output logic [7:0]                    drop_count
);

  typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

  localparam int BW = BUFFER_BYTE_SIZE * 8;
  localparam logic [BUFFER_INDEX_SIZE-1:0] FULL = BUFFER_INDEX_SIZE'(BUFFER_BYTE_SIZE);
  localparam logic [BUFFER_INDEX_SIZE-1:0] TMO  = BUFFER_INDEX_SIZE'(IDLE_TIMEOUT_TICKS);
  localparam logic [BUFFER_INDEX_SIZE-1:0] ONE  = BUFFER_INDEX_SIZE'(1);

  state_t                       state;
  logic [BUFFER_INDEX_SIZE-1:0] idx;
  logic [BUFFER_INDEX_SIZE-1:0] timer;
  logic [BUFFER_INDEX_SIZE-1:0] idx_inc;
  logic [BUFFER_INDEX_SIZE-1:0] timer_inc;
  logic [BW-1:0]                first_buf;
  logic [BW-1:0]                ins_buf;

  // chunk_bytes doubles as the working buffer; it is only frozen while in HOLD
  always_comb begin
    first_buf      = '0;
    first_buf[7:0] = rx_data;
    ins_buf        = chunk_bytes;
    for (int k = 0; k < BUFFER_BYTE_SIZE; k++) begin
      if (idx == BUFFER_INDEX_SIZE'(k)) ins_buf[8*k +: 8] = rx_data;
    end
  end

  assign idx_inc   = idx + ONE;
  assign timer_inc = timer + ONE;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state           <= IDLE;
      idx             <= '0;
      timer           <= '0;
      is_chunk_ready  <= 1'b0;
      chunk_byte_size <= '0;
      chunk_bytes     <= '0;
      is_overflow     <= 1'b0;
      drop_count      <= '0;
    end else begin
      is_overflow <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_ready) begin
            chunk_bytes <= first_buf;
            idx         <= ONE;
            timer       <= '0;
            if (FULL == ONE) begin
              state           <= HOLD;
              is_chunk_ready  <= 1'b1;
              chunk_byte_size <= ONE;
            end else begin
              state <= COLLECT;
            end
          end
        end
        COLLECT: begin
          if (rx_ready) begin
            chunk_bytes <= ins_buf;
            idx         <= idx_inc;
            timer       <= '0;
            if (idx_inc == FULL) begin
              state           <= HOLD;
              is_chunk_ready  <= 1'b1;
              chunk_byte_size <= FULL;
            end
          end else begin
            timer <= timer_inc;
            if (IDLE_TIMEOUT_TICKS != 0 && timer_inc == TMO) begin
              state           <= HOLD;
              is_chunk_ready  <= 1'b1;
              chunk_byte_size <= idx;
            end
          end
        end
        HOLD: begin
          if (chunk_ack) begin
            is_chunk_ready  <= 1'b0;
            chunk_byte_size <= '0;
            state           <= IDLE;
            // a byte arriving with the ack opens the next chunk immediately
            if (rx_ready) begin
              chunk_bytes <= first_buf;
              idx         <= ONE;
              timer       <= '0;
              if (FULL == ONE) begin
                state           <= HOLD;
                is_chunk_ready  <= 1'b1;
                chunk_byte_size <= ONE;
              end else begin
                state <= COLLECT;
              end
            end
          end else if (rx_ready) begin
            is_overflow <= 1'b1;
            if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_chunker.sv
// Bench for uart_rx_chunker (3-byte chunks, 16-tick idle timeout): vector table plus hand-written corner sequences.
module tb_uart_rx_chunker;

  logic        CLK;
  logic        RST_N;
  logic        rx_ready;
  logic [7:0]  rx_data;
  logic        chunk_ack;
  logic        is_chunk_ready;
  logic [31:0] chunk_byte_size;
  logic [23:0] chunk_bytes;
  logic        is_overflow;
  logic [7:0]  drop_count;

  uart_rx_chunker #(
    .BUFFER_BYTE_SIZE(3),
    .BUFFER_INDEX_SIZE(32),
    .IDLE_TIMEOUT_TICKS(16)
  ) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .rx_ready(rx_ready),
    .rx_data(rx_data),
    .chunk_ack(chunk_ack),
    .is_chunk_ready(is_chunk_ready),
    .chunk_byte_size(chunk_byte_size),
    .chunk_bytes(chunk_bytes),
    .is_overflow(is_overflow),
    .drop_count(drop_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        rdy;
    logic [7:0]  dat;
    logic        ack;
    logic        exp_rdy;
    logic [31:0] exp_size;
    logic [23:0] exp_bytes;
    logic        exp_ovf;
    logic [7:0]  exp_drop;
  } vec_t;

  typedef struct packed {
    logic [31:0] size;
    logic [23:0] bytes;
  } chunk_t;

  vec_t   vecs[13];
  chunk_t sb_q[$];
  int     passed = 0;
  int     total  = 0;
  logic   prev_ready = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  task automatic check_out(input string tag, input logic rdy, input logic [31:0] size,
                           input logic [23:0] bytes, input logic ovf, input logic [7:0] drop);
    check({tag, ".ready"}, 64'(is_chunk_ready), 64'(rdy));
    check({tag, ".size"},  64'(chunk_byte_size), 64'(size));
    check({tag, ".bytes"}, 64'(chunk_bytes), 64'(bytes));
    check({tag, ".ovf"},   64'(is_overflow), 64'(ovf));
    check({tag, ".drop"},  64'(drop_count), 64'(drop));
  endtask

  // one clock: drive inputs, take the edge, sample 1ns later and score any newly presented chunk
  task automatic step(input logic rdy, input logic [7:0] dat, input logic ack);
    chunk_t e;
    rx_ready  = rdy;
    rx_data   = dat;
    chunk_ack = ack;
    @(posedge CLK);
    #1;
    if (is_chunk_ready && !prev_ready) begin
      if (sb_q.size() == 0) begin
        total++;
        $display("FAIL sb_unexpected: got chunk %0h size %0d expected none", chunk_bytes, chunk_byte_size);
      end else begin
        e = sb_q.pop_front();
        check("sb_size", 64'(chunk_byte_size), 64'(e.size));
        check("sb_bytes", 64'(chunk_bytes), 64'(e.bytes));
      end
    end
    prev_ready = is_chunk_ready;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
  endtask

  task automatic do_reset();
    RST_N     = 1'b0;
    rx_ready  = 1'b0;
    rx_data   = 8'h00;
    chunk_ack = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RST_N      = 1'b1;
    prev_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{1'b1, 8'h41, 1'b0, 1'b0, 32'd0, 24'h000041, 1'b0, 8'd0};
    vecs[1]  = '{1'b1, 8'h42, 1'b0, 1'b0, 32'd0, 24'h004241, 1'b0, 8'd0};
    vecs[2]  = '{1'b1, 8'h43, 1'b0, 1'b1, 32'd3, 24'h434241, 1'b0, 8'd0};
    vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b1, 32'd3, 24'h434241, 1'b0, 8'd0};
    vecs[4]  = '{1'b1, 8'h55, 1'b0, 1'b1, 32'd3, 24'h434241, 1'b1, 8'd1};
    vecs[5]  = '{1'b0, 8'h00, 1'b0, 1'b1, 32'd3, 24'h434241, 1'b0, 8'd1};
    vecs[6]  = '{1'b1, 8'h55, 1'b0, 1'b1, 32'd3, 24'h434241, 1'b1, 8'd2};
    vecs[7]  = '{1'b1, 8'h77, 1'b1, 1'b0, 32'd0, 24'h000077, 1'b0, 8'd2};
    vecs[8]  = '{1'b1, 8'h88, 1'b0, 1'b0, 32'd0, 24'h008877, 1'b0, 8'd2};
    vecs[9]  = '{1'b1, 8'h99, 1'b0, 1'b1, 32'd3, 24'h998877, 1'b0, 8'd2};
    vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 32'd0, 24'h998877, 1'b0, 8'd2};
    vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 32'd0, 24'h998877, 1'b0, 8'd2};
    vecs[12] = '{1'b1, 8'h01, 1'b0, 1'b0, 32'd0, 24'h000001, 1'b0, 8'd2};

    do_reset();
    check_out("reset", 1'b0, 32'd0, 24'h0, 1'b0, 8'd0);

    // full chunk with 10-cycle byte spacing
    step(1'b1, 8'h41, 1'b0);
    idle(9);
    step(1'b1, 8'h42, 1'b0);
    idle(8);
    step(1'b0, 8'h00, 1'b0);
    check("t1.not_ready_before_last", 64'(is_chunk_ready), 64'd0);
    sb_q.push_back('{size: 32'd3, bytes: 24'h434241});
    step(1'b1, 8'h43, 1'b0);
    check_out("t1.full", 1'b1, 32'd3, 24'h434241, 1'b0, 8'd0);
    step(1'b0, 8'h00, 1'b1);
    check_out("t1.ack", 1'b0, 32'd0, 24'h434241, 1'b0, 8'd0);

    // drops while held, ack+byte restart, ack outside HOLD
    for (int i = 0; i < 13; i++) begin
      if (vecs[i].exp_rdy && !(i > 0 && vecs[i-1].exp_rdy))
        sb_q.push_back('{size: vecs[i].exp_size, bytes: vecs[i].exp_bytes});
      step(vecs[i].rdy, vecs[i].dat, vecs[i].ack);
      check_out($sformatf("vec%0d", i), vecs[i].exp_rdy, vecs[i].exp_size,
                vecs[i].exp_bytes, vecs[i].exp_ovf, vecs[i].exp_drop);
    end

    // idle timeout closes a 2-byte chunk exactly 16 edges after the last capture
    do_reset();
    step(1'b1, 8'h10, 1'b0);
    sb_q.push_back('{size: 32'd2, bytes: 24'h002010});
    step(1'b1, 8'h20, 1'b0);
    for (int i = 1; i <= 16; i++) begin
      step(1'b0, 8'h00, 1'b0);
      if (i >= 14) check($sformatf("t2.ready_at_%0d", i), 64'(is_chunk_ready), 64'(i == 16));
    end
    check_out("t2.timeout", 1'b1, 32'd2, 24'h002010, 1'b0, 8'd0);
    step(1'b0, 8'h00, 1'b1);

    // byte on the timeout cycle is captured and restarts the timer
    step(1'b1, 8'h30, 1'b0);
    idle(15);
    step(1'b1, 8'h31, 1'b0);
    check_out("t6.capture_wins", 1'b0, 32'd0, 24'h003130, 1'b0, 8'd0);
    sb_q.push_back('{size: 32'd2, bytes: 24'h003130});
    for (int i = 1; i <= 16; i++) begin
      step(1'b0, 8'h00, 1'b0);
      if (i >= 15) check($sformatf("t6.ready_at_%0d", i), 64'(is_chunk_ready), 64'(i == 16));
    end
    check_out("t6.timeout", 1'b1, 32'd2, 24'h003130, 1'b0, 8'd0);

    // drop_count saturates
    for (int i = 0; i < 300; i++) step(1'b1, 8'h55, 1'b0);
    check_out("t3.saturate", 1'b1, 32'd2, 24'h003130, 1'b1, 8'd255);
    step(1'b0, 8'h00, 1'b1);
    check_out("t3.ack", 1'b0, 32'd0, 24'h003130, 1'b0, 8'd255);

    // asynchronous reset between edges discards a partial chunk
    step(1'b1, 8'hA1, 1'b0);
    step(1'b1, 8'hA2, 1'b0);
    check("t5.partial", 64'(chunk_bytes), 64'h00A2A1);
    rx_ready = 1'b0;
    #3;
    RST_N = 1'b0;
    #1;
    check_out("t5.async", 1'b0, 32'd0, 24'h0, 1'b0, 8'd0);
    RST_N = 1'b1;
    prev_ready = 1'b0;
    step(1'b1, 8'hC1, 1'b0);
    check("t5.fresh_byte0", 64'(chunk_bytes), 64'h0000C1);
    step(1'b1, 8'hC2, 1'b0);
    sb_q.push_back('{size: 32'd3, bytes: 24'hC3C2C1});
    step(1'b1, 8'hC3, 1'b0);
    check_out("t5.chunk", 1'b1, 32'd3, 24'hC3C2C1, 1'b0, 8'd0);
    step(1'b0, 8'h00, 1'b1);

    check("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/uart_rx_chunker.md
Name: uart_rx_chunker

Overview:
Collects single bytes from the uart_rx byte-valid stream into a fixed-capacity chunk buffer. It presents the buffer to downstream logic once the chunk is full, or once the line has been idle for a programmable number of ticks. It sits directly downstream of uart_rx and is the receive-side counterpart of uart_tx_chunker. It uses the same chunk layout (byte k in bits [8k+7:8k]) and the same size-field convention.

Parameters:
BUFFER_BYTE_SIZE, 3, chunk capacity in bytes (>=1)
BUFFER_INDEX_SIZE, 32, width of chunk_byte_size and the idle timer
IDLE_TIMEOUT_TICKS, 100000, CLK cycles of line silence that close a partial chunk; 0 disables the timeout

Ports:
CLK  input  1  system clock, all logic on posedge
RST_N  input  1  asynchronous active-low reset
rx_ready  input  1  one-cycle byte-valid pulse from uart_rx
rx_data  input  8  received byte, valid when rx_ready=1
chunk_ack  input  1  consumer has taken the presented chunk
is_chunk_ready  output  1  chunk is presented; level, held until acked
chunk_byte_size  output  BUFFER_INDEX_SIZE  number of valid bytes in chunk_bytes (1..BUFFER_BYTE_SIZE)
chunk_bytes  output  BUFFER_BYTE_SIZE*8  chunk data, byte k at [8k+7:8k], unused bytes zero
is_overflow  output  1  one-cycle pulse when a byte is dropped
drop_count  output  8  saturating count of dropped bytes

Behaviour:
- Reset (RST_N=0, asynchronous):
  - State goes to IDLE.
  - All outputs are 0; buffer, byte index and timer are cleared.
  - A reset mid-chunk or mid-hold discards the partial chunk.
- Registered outputs: everything updates on posedge CLK only.
- IDLE state:
  - On rx_ready, the buffer becomes {zeros, rx_data}, the index becomes 1 and the timer becomes 0.
  - If BUFFER_BYTE_SIZE==1 the next state is HOLD; otherwise it is COLLECT.
- COLLECT state:
  - On rx_ready, rx_data is written to byte[index], the index increments and the timer clears.
  - If the new index equals BUFFER_BYTE_SIZE, the next state is HOLD.
  - Without rx_ready the timer increments.
  - When IDLE_TIMEOUT_TICKS!=0 and the incremented timer reaches IDLE_TIMEOUT_TICKS, the next state is HOLD with the current index. HOLD is therefore entered exactly IDLE_TIMEOUT_TICKS edges after the last capture edge.
  - If rx_ready arrives on the timeout cycle, the capture wins and the timer restarts.
- HOLD state:
  - is_chunk_ready=1, chunk_byte_size=index, and chunk_bytes is stable for the whole hold.
  - is_chunk_ready rises on the same edge that captures the final byte or detects the timeout, so latency is 0 cycles after the sampling edge.
  - On chunk_ack, is_chunk_ready drops on that edge. If rx_ready is also high on that cycle, the byte starts a new chunk (IDLE capture rules, next state COLLECT or HOLD). Otherwise the next state is IDLE.
  - rx_ready without chunk_ack drops the byte: is_overflow pulses for 1 cycle and drop_count increments, saturating at 255.
- chunk_ack outside HOLD is ignored.
- Index arithmetic: the index never exceeds BUFFER_BYTE_SIZE. chunk_byte_size is zero-extended to BUFFER_INDEX_SIZE.
- Outputs while not in HOLD:
  - chunk_bytes holds the last buffer contents.
  - chunk_byte_size holds 0.
- The consumer must only sample chunk_bytes while is_chunk_ready=1.

Test Plan:
1. Reset, then rx bytes 0x41, 0x42, 0x43, 10 cycles apart (BUFFER_BYTE_SIZE=3) -> is_chunk_ready=1 on the edge sampling 0x43, chunk_bytes=0x434241, chunk_byte_size=3; ack -> is_chunk_ready=0 next edge.
2. IDLE_TIMEOUT_TICKS=16, rx 0x10 then 0x20, silence -> exactly 16 edges after the 0x20 capture, is_chunk_ready=1, chunk_byte_size=2, chunk_bytes=0x002010.
3. Chunk held, no ack, rx 0x55 twice -> two is_overflow pulses, drop_count=2, chunk_bytes unchanged; 300 further drops -> drop_count=255.
4. Chunk held, chunk_ack and rx_ready(0x77) on the same cycle -> is_chunk_ready=0, new chunk starts with byte0=0x77 and upper bytes zero; after the next two bytes, a full chunk is presented.
5. RST_N low asynchronously after 2 of 3 bytes (between edges) -> outputs 0 immediately; after release, 3 fresh bytes form a chunk with no stale data.
6. rx_ready on the exact timeout cycle (timer=15 of 16) -> byte captured into the chunk, no premature HOLD, timeout restarts from that capture.
